// File: rtl/stage_decode_pipe.sv
// ID/EX decode stage: decodes register selects from the fetched word, checks for
// load-use hazards against the instruction held in ID/EX, and registers the
// decoded fields behind a valid/ready handshake with branch flush.
// Optional feature macro: DECODE_STALL_CNT_EN adds a saturating hazard-bubble counter.
module stage_decode_pipe #(
  parameter int unsigned      INSN_W   = 32,
  parameter int unsigned      PC_W     = 32,
  parameter int unsigned      REG_W    = 5,
  parameter logic [REG_W-1:0] LINK_REG = 15,
  parameter logic [4:0]       OP_LW    = 5'b01000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [INSN_W-1:0] if_insn,
  input  logic [PC_W-1:0]   if_pc,
  output logic              id_ready,
  output logic [REG_W-1:0]  ctrl_readRegA,
  output logic [REG_W-1:0]  ctrl_readRegB,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [INSN_W-1:0] ex_insn,
  output logic [PC_W-1:0]   ex_pc,
  output logic [4:0]        ex_opcode,
  output logic [4:0]        ex_alu_op,
  output logic [REG_W-1:0]  ex_writeReg,
  output logic              ex_writes_reg,
`ifdef DECODE_STALL_CNT_EN
  output logic [31:0]       stall_count,
`endif
  output logic              ex_is_load
);

  localparam int unsigned OpcLsb = INSN_W - 5;
  localparam int unsigned RdLsb  = OpcLsb - REG_W;
  localparam int unsigned RsLsb  = RdLsb - REG_W;
  localparam int unsigned RtLsb  = RsLsb - REG_W;

  logic [4:0]       opcode;
  logic [REG_W-1:0] rd, rs, rt;
  logic             r_insn, jal, uses_a, uses_b;
  logic [REG_W-1:0] read_b;
  logic [REG_W-1:0] write_reg;
  logic             writes_reg, is_load;
  logic [4:0]       alu_op;
  logic             hazard, advance;

  logic              ex_valid_d, ex_valid_q;
  logic [INSN_W-1:0] ex_insn_d, ex_insn_q;
  logic [PC_W-1:0]   ex_pc_d, ex_pc_q;
  logic [4:0]        ex_opcode_d, ex_opcode_q;
  logic [4:0]        ex_alu_op_d, ex_alu_op_q;
  logic [REG_W-1:0]  ex_write_reg_d, ex_write_reg_q;
  logic              ex_writes_reg_d, ex_writes_reg_q;
  logic              ex_is_load_d, ex_is_load_q;

  assign opcode = if_insn[OpcLsb +: 5];
  assign rd     = if_insn[RdLsb +: REG_W];
  assign rs     = if_insn[RsLsb +: REG_W];
  assign rt     = if_insn[RtLsb +: REG_W];

  // Field decode of the incoming word; also feeds the register-file read ports.
  always_comb begin
    r_insn     = (opcode == 5'b00000);
    jal        = (opcode == 5'b00011);
    is_load    = (opcode == OP_LW);
    uses_a     = !((opcode == 5'b00001) || jal);
    uses_b     = r_insn || (opcode == 5'b00010) || (opcode == 5'b00100) ||
                 (opcode == 5'b00110) || (opcode == 5'b00111);
    read_b     = r_insn ? rt : rd;
    write_reg  = jal ? LINK_REG : rd;
    // A write to r0 is discarded, so it must never look like a producer.
    writes_reg = (r_insn || (opcode == 5'b00101) || is_load || jal) && (write_reg != '0);
    alu_op     = r_insn ? if_insn[6:2] : 5'b00000;
  end

  // Load-use detection against ID/EX and the handshake toward fetch.
  always_comb begin
    hazard   = if_valid && ex_valid_q && ex_is_load_q && ex_writes_reg_q &&
               ((uses_a && (rs == ex_write_reg_q)) || (uses_b && (read_b == ex_write_reg_q)));
    advance  = ex_ready || !ex_valid_q;
    id_ready = advance && !hazard && !flush;
  end

  // Next-state of the ID/EX register: flush, then bubble, then capture, else hold.
  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_insn_d       = ex_insn_q;
    ex_pc_d         = ex_pc_q;
    ex_opcode_d     = ex_opcode_q;
    ex_alu_op_d     = ex_alu_op_q;
    ex_write_reg_d  = ex_write_reg_q;
    ex_writes_reg_d = ex_writes_reg_q;
    ex_is_load_d    = ex_is_load_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (advance && hazard) begin
      ex_valid_d = 1'b0;
    end else if (advance) begin
      ex_valid_d = if_valid;
      if (if_valid) begin
        ex_insn_d       = if_insn;
        ex_pc_d         = if_pc;
        ex_opcode_d     = opcode;
        ex_alu_op_d     = alu_op;
        ex_write_reg_d  = write_reg;
        ex_writes_reg_d = writes_reg;
        ex_is_load_d    = is_load;
      end
    end
  end

  // ID/EX pipeline register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid_q      <= 1'b0;
      ex_insn_q       <= '0;
      ex_pc_q         <= '0;
      ex_opcode_q     <= '0;
      ex_alu_op_q     <= '0;
      ex_write_reg_q  <= '0;
      ex_writes_reg_q <= 1'b0;
      ex_is_load_q    <= 1'b0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_insn_q       <= ex_insn_d;
      ex_pc_q         <= ex_pc_d;
      ex_opcode_q     <= ex_opcode_d;
      ex_alu_op_q     <= ex_alu_op_d;
      ex_write_reg_q  <= ex_write_reg_d;
      ex_writes_reg_q <= ex_writes_reg_d;
      ex_is_load_q    <= ex_is_load_d;
    end
  end

`ifdef DECODE_STALL_CNT_EN
  logic [31:0] stall_count_d, stall_count_q;

  // Count inserted load-use bubbles; a flush in the same cycle is not a bubble.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!flush && advance && hazard && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // Bubble counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

  assign ctrl_readRegA = rs;
  assign ctrl_readRegB = read_b;
  assign ex_valid      = ex_valid_q;
  assign ex_insn       = ex_insn_q;
  assign ex_pc         = ex_pc_q;
  assign ex_opcode     = ex_opcode_q;
  assign ex_alu_op     = ex_alu_op_q;
  assign ex_writeReg   = ex_write_reg_q;
  assign ex_writes_reg = ex_writes_reg_q;
  assign ex_is_load    = ex_is_load_q;

endmodule

// File: tb/tb_stage_decode_pipe.sv
// Self-checking bench for stage_decode_pipe: directed scenarios plus a randomized
// run against a reference model of the ID/EX slot.
module tb_stage_decode_pipe;

  logic        clock = 1'b0;
  logic        reset, flush, if_valid, ex_ready;
  logic [31:0] if_insn, if_pc;
  logic        id_ready, ex_valid, ex_writes_reg, ex_is_load;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB, ex_opcode, ex_alu_op, ex_writeReg;
  logic [31:0] ex_insn, ex_pc;
`ifdef DECODE_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  stage_decode_pipe dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .if_valid      (if_valid),
    .if_insn       (if_insn),
    .if_pc         (if_pc),
    .id_ready      (id_ready),
    .ctrl_readRegA (ctrl_readRegA),
    .ctrl_readRegB (ctrl_readRegB),
    .ex_ready      (ex_ready),
    .ex_valid      (ex_valid),
    .ex_insn       (ex_insn),
    .ex_pc         (ex_pc),
    .ex_opcode     (ex_opcode),
    .ex_alu_op     (ex_alu_op),
    .ex_writeReg   (ex_writeReg),
    .ex_writes_reg (ex_writes_reg),
`ifdef DECODE_STALL_CNT_EN
    .stall_count   (stall_count),
`endif
    .ex_is_load    (ex_is_load)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decode, written straight from the field layout with arithmetic.
  function automatic logic [31:0] mk(int op, int rd, int rs, int rt, int low);
    return (op << 27) + (rd << 22) + (rs << 17) + (rt << 12) + (low % 4096);
  endfunction
  function automatic int f_op(logic [31:0] w); return int'(w >> 27); endfunction
  function automatic int f_rd(logic [31:0] w); return int'((w >> 22) % 32); endfunction
  function automatic int f_rs(logic [31:0] w); return int'((w >> 17) % 32); endfunction
  function automatic int f_rt(logic [31:0] w); return int'((w >> 12) % 32); endfunction
  function automatic int r_readb(logic [31:0] w);
    return (f_op(w) == 0) ? f_rt(w) : f_rd(w);
  endfunction
  function automatic int r_dest(logic [31:0] w);
    return (f_op(w) == 3) ? 15 : f_rd(w);
  endfunction
  function automatic bit r_writes(logic [31:0] w);
    int op = f_op(w);
    return (op == 0 || op == 5 || op == 8 || op == 3) && r_dest(w) != 0;
  endfunction
  function automatic int r_alu(logic [31:0] w);
    return (f_op(w) == 0) ? int'((w >> 2) % 32) : 0;
  endfunction
  function automatic bit r_uses_a(logic [31:0] w);
    return !(f_op(w) == 1 || f_op(w) == 3);
  endfunction
  function automatic bit r_uses_b(logic [31:0] w);
    int op = f_op(w);
    return op == 0 || op == 2 || op == 4 || op == 6 || op == 7;
  endfunction
  // Packed view of the decoded ID/EX fields expected for a given stored word.
  function automatic logic [16:0] r_fields(logic [31:0] w);
    logic [4:0] op, alu, dst;
    op  = 5'(f_op(w));
    alu = 5'(r_alu(w));
    dst = 5'(r_dest(w));
    return {op, alu, dst, r_writes(w), f_op(w) == 8};
  endfunction

  task automatic apply_reset();
    reset = 1'b1; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    if_insn = '0; if_pc = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b1; if_valid = 1'b1; ex_ready = 1'b1;
    if_insn = mk(0, 3, 1, 2, 5); if_pc = 32'h1234;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({ex_valid, ex_insn, ex_pc} !== 65'd0) begin
      errors++; $display("FAIL reset_state: valid/insn/pc=%h required 0", {ex_valid, ex_insn, ex_pc});
    end
    checks++;
    if ({ex_opcode, ex_alu_op, ex_writeReg, ex_writes_reg, ex_is_load} !== 17'd0) begin
      errors++; $display("FAIL reset_fields: got %h required 0",
                         {ex_opcode, ex_alu_op, ex_writeReg, ex_writes_reg, ex_is_load});
    end
`ifdef DECODE_STALL_CNT_EN
    checks++;
    if (stall_count !== 32'd0) begin
      errors++; $display("FAIL reset_stall_count: got %0d required 0", stall_count);
    end
`endif
    reset = 1'b0; flush = 1'b0; if_valid = 1'b0;
  endtask

  task automatic test_stream();
    apply_reset();
    if_valid = 1'b1; if_insn = mk(0, 3, 1, 2, 32'h54); if_pc = 32'h10;
    #2;
    checks++;
    if ({ctrl_readRegA, ctrl_readRegB, id_ready} !== {5'd1, 5'd2, 1'b1}) begin
      errors++; $display("FAIL stream_issue: A=%0d B=%0d rdy=%b required 1 2 1",
                         ctrl_readRegA, ctrl_readRegB, id_ready);
    end
    @(posedge clock); #1;
    checks++;
    if ({ex_valid, ex_writeReg, ex_writes_reg, ex_alu_op} !== {1'b1, 5'd3, 1'b1, 5'd21}) begin
      errors++; $display("FAIL stream_capture: v=%b wr=%0d we=%b alu=%0d required 1 3 1 21",
                         ex_valid, ex_writeReg, ex_writes_reg, ex_alu_op);
    end
    if_valid = 1'b0;
  endtask

  task automatic test_jal_itype();
    apply_reset();
    if_valid = 1'b1; if_insn = mk(3, 9, 9, 9, 0); if_pc = 32'h40;
    @(posedge clock); #1;
    checks++;
    if ({ex_valid, ex_writeReg, ex_writes_reg, ex_pc} !== {1'b1, 5'd15, 1'b1, 32'h40}) begin
      errors++; $display("FAIL jal_link: v=%b wr=%0d we=%b pc=%h required 1 15 1 40",
                         ex_valid, ex_writeReg, ex_writes_reg, ex_pc);
    end
    if_insn = mk(5, 4, 5, 0, 7); if_pc = 32'h44;
    #2;
    checks++;
    if ({ctrl_readRegA, ctrl_readRegB} !== {5'd5, 5'd4}) begin
      errors++; $display("FAIL addi_selects: A=%0d B=%0d required 5 4", ctrl_readRegA, ctrl_readRegB);
    end
    @(posedge clock); #1;
    checks++;
    if ({ex_writeReg, ex_writes_reg, ex_alu_op} !== {5'd4, 1'b1, 5'd0}) begin
      errors++; $display("FAIL addi_capture: wr=%0d we=%b alu=%0d required 4 1 0",
                         ex_writeReg, ex_writes_reg, ex_alu_op);
    end
    if_valid = 1'b0;
  endtask

  task automatic test_load_use();
    logic [31:0] add_w;
    add_w = mk(0, 7, 6, 1, 0);
    apply_reset();
    if_valid = 1'b1; if_insn = mk(8, 6, 2, 0, 0);
    @(posedge clock); #1;
    if_insn = add_w;
    #2;
    checks++;
    if (id_ready !== 1'b0) begin
      errors++; $display("FAIL load_use_stall: id_ready=%b required 0", id_ready);
    end
    @(posedge clock); #1;
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++; $display("FAIL load_use_bubble: ex_valid=%b required 0", ex_valid);
    end
    #2;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++; $display("FAIL load_use_release: id_ready=%b required 1", id_ready);
    end
    @(posedge clock); #1;
    checks++;
    if ({ex_valid, ex_insn} !== {1'b1, add_w}) begin
      errors++; $display("FAIL load_use_add: v=%b insn=%h required 1 %h", ex_valid, ex_insn, add_w);
    end
`ifdef DECODE_STALL_CNT_EN
    checks++;
    if (stall_count !== 32'd1) begin
      errors++; $display("FAIL load_use_count: stall_count=%0d required 1", stall_count);
    end
`endif
    if_valid = 1'b0;
  endtask

  task automatic test_no_false_hazard();
    apply_reset();
    if_valid = 1'b1; if_insn = mk(8, 0, 2, 0, 0);
    @(posedge clock); #1;
    if_insn = mk(0, 1, 0, 0, 0);
    #2;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++; $display("FAIL r0_no_hazard: id_ready=%b required 1", id_ready);
    end
    @(posedge clock); #1;
    if_insn = mk(8, 6, 2, 0, 0);
    @(posedge clock); #1;
    if_insn = mk(1, 6, 6, 6, 0);
    #2;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++; $display("FAIL j_no_hazard: id_ready=%b required 1", id_ready);
    end
    @(posedge clock); #1;
    checks++;
    if ({ex_valid, ex_opcode} !== {1'b1, 5'd1}) begin
      errors++; $display("FAIL j_captured: v=%b op=%0d required 1 1", ex_valid, ex_opcode);
    end
    if_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] a_w, b_w;
    a_w = mk(0, 3, 1, 2, 0);
    b_w = mk(5, 9, 4, 0, 3);
    apply_reset();
    if_valid = 1'b1; if_insn = a_w;
    @(posedge clock); #1;
    ex_ready = 1'b0; if_insn = b_w;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (id_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready[%0d]: id_ready=%b required 0", i, id_ready);
      end
      @(posedge clock); #1;
      checks++;
      if ({ex_valid, ex_insn} !== {1'b1, a_w}) begin
        errors++; $display("FAIL bp_hold[%0d]: v=%b insn=%h required 1 %h", i, ex_valid, ex_insn, a_w);
      end
    end
    ex_ready = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({ex_valid, ex_insn} !== {1'b1, b_w}) begin
      errors++; $display("FAIL bp_release: v=%b insn=%h required 1 %h", ex_valid, ex_insn, b_w);
    end
    if_valid = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] lw_w;
    lw_w = mk(8, 6, 2, 0, 0);
    apply_reset();
    if_valid = 1'b1; if_insn = lw_w;
    @(posedge clock); #1;
    if_insn = mk(0, 7, 6, 1, 0); flush = 1'b1;
    #2;
    checks++;
    if (id_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: id_ready=%b required 0", id_ready);
    end
    @(posedge clock); #1;
    checks++;
    if ({ex_valid, ex_insn} !== {1'b0, lw_w}) begin
      errors++; $display("FAIL flush_kill: v=%b insn=%h required 0 %h", ex_valid, ex_insn, lw_w);
    end
`ifdef DECODE_STALL_CNT_EN
    checks++;
    if (stall_count !== 32'd0) begin
      errors++; $display("FAIL flush_count: stall_count=%0d required 0", stall_count);
    end
`endif
    flush = 1'b0; if_valid = 1'b0;
  endtask

  task automatic test_random();
    bit          m_valid;
    logic [31:0] m_insn, m_pc;
    int unsigned m_stall;
    bit          hz, adv, e_rdy;
    apply_reset();
    m_valid = 0; m_insn = '0; m_pc = '0; m_stall = 0;
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 60) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      if_valid = ($urandom_range(0, 9) < 7);
      ex_ready = ($urandom_range(0, 9) < 7);
      if_pc    = $urandom;
      if_insn  = mk(($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 8),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      hz = if_valid && m_valid && f_op(m_insn) == 8 && r_writes(m_insn) &&
           ((r_uses_a(if_insn) && f_rs(if_insn) == r_dest(m_insn)) ||
            (r_uses_b(if_insn) && r_readb(if_insn) == r_dest(m_insn)));
      adv   = ex_ready || !m_valid;
      e_rdy = adv && !hz && !flush;
      #2;
      if (!reset) begin
        checks++;
        if ({id_ready, ctrl_readRegA, ctrl_readRegB} !==
            {e_rdy, 5'(f_rs(if_insn)), 5'(r_readb(if_insn))}) begin
          errors++; $display("FAIL rnd_comb[%0d]: rdy=%b A=%0d B=%0d required %b %0d %0d", n,
                             id_ready, ctrl_readRegA, ctrl_readRegB, e_rdy, f_rs(if_insn),
                             r_readb(if_insn));
        end
      end
      if (reset) begin
        m_valid = 0; m_insn = '0; m_pc = '0; m_stall = 0;
      end else if (flush) begin
        m_valid = 0;
      end else if (adv && hz) begin
        m_valid = 0;
        if (m_stall != 32'hFFFF_FFFF) m_stall++;
      end else if (adv) begin
        m_valid = if_valid;
        if (if_valid) begin
          m_insn = if_insn; m_pc = if_pc;
        end
      end
      @(posedge clock); #1;
      checks++;
      if ({ex_valid, ex_insn, ex_pc} !== {m_valid, m_insn, m_pc}) begin
        errors++; $display("FAIL rnd_slot[%0d]: v=%b insn=%h pc=%h required %b %h %h", n,
                           ex_valid, ex_insn, ex_pc, m_valid, m_insn, m_pc);
      end
      checks++;
      if ({ex_opcode, ex_alu_op, ex_writeReg, ex_writes_reg, ex_is_load} !== r_fields(m_insn)) begin
        errors++; $display("FAIL rnd_fields[%0d]: got %h required %h", n,
                           {ex_opcode, ex_alu_op, ex_writeReg, ex_writes_reg, ex_is_load},
                           r_fields(m_insn));
      end
`ifdef DECODE_STALL_CNT_EN
      checks++;
      if (stall_count !== m_stall) begin
        errors++; $display("FAIL rnd_stall[%0d]: got %0d required %0d", n, stall_count, m_stall);
      end
`endif
    end
    reset = 1'b0; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    if_insn = '0; if_pc = '0;
    #1;
    test_reset();
    test_stream();
    test_jal_itype();
    test_load_use();
    test_no_false_hazard();
    test_backpressure();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_decode_pipe.md
Name: stage_decode_pipe

Overview:
- Parametrised successor to the combinational decode stage.
- Decodes register selects from the fetched instruction word and registers the decoded fields into an ID/EX pipeline register.
- Uses a valid/ready handshake, detects load-use hazards, and supports branch flush.
- Sits between the fetch stage (IF/ID) and execute; drives the register-file read addresses combinationally.

Parameters:
- INSN_W, 32, instruction word width; opcode [INSN_W-1 -: 5], rd next 5, rs next 5, rt next 5, ALU_op [6:2]
- PC_W, 32, program-counter width carried alongside the instruction
- REG_W, 5, register address width
- LINK_REG, 15, destination register written by jal
- OP_LW, 5'b01000, load opcode used for hazard detection

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  branch/jump resolved taken; kill ID/EX contents and current input
- if_valid  input  1  fetch presents a valid instruction
- if_insn  input  INSN_W  instruction word
- if_pc  input  PC_W  PC of if_insn
- id_ready  output  1  decode accepts if_insn this cycle
- ctrl_readRegA  output  REG_W  regfile port A address = rs (combinational)
- ctrl_readRegB  output  REG_W  regfile port B address: rt for R-type, else rd (combinational)
- ex_ready  input  1  execute accepts ID/EX contents
- ex_valid  output  1  ID/EX register holds a valid instruction
- ex_insn  output  INSN_W  registered instruction
- ex_pc  output  PC_W  registered PC
- ex_opcode  output  5  registered opcode
- ex_alu_op  output  5  registered ALU_op (zero for non-R-type)
- ex_writeReg  output  REG_W  registered destination: LINK_REG for jal, else rd
- ex_writes_reg  output  1  registered write-enable: R-type, addi 00101, lw, jal; forced 0 when destination is r0
- ex_is_load  output  1  registered opcode==OP_LW

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high. Reset clears every register and output to 0. ex_valid=0 the cycle after reset is sampled high. Reset overrides flush and the handshake.
- Combinational decode:
  - r_insn = opcode==00000; jal = opcode==00011.
  - uses_A: all opcodes except j 00001 and jal 00011.
  - uses_B: R-type, bne 00010, jr 00100, blt 00110, sw 00111.
- hazard = if_valid & ex_valid & ex_is_load & ex_writes_reg & ((uses_A & readRegA==ex_writeReg) | (uses_B & readRegB==ex_writeReg)).
- advance = ex_ready | ~ex_valid.
- id_ready = advance & ~hazard & ~flush.
- Per rising edge, in priority order:
  1. reset: clear all.
  2. flush: ex_valid<=0. The input instruction is dropped, not accepted.
  3. advance & hazard: insert a bubble (ex_valid<=0). The input is held by fetch and re-presented next cycle.
  4. advance: ex_valid<=if_valid and capture all ex_* fields. Data fields are captured only when if_valid=1.
  5. otherwise: hold all ex_* values unchanged.
- Latency: 1 cycle from an accepted input to ex_valid.
- Throughput: 1 instruction/cycle with no hazard.
- Load-use costs exactly 1 bubble. On the next cycle the load has left ID/EX, so the hazard clears.
- A stalled ID/EX (ex_ready=0) keeps ex_* stable. Its ex_is_load remains visible for hazard evaluation.
- r0 destination never causes a hazard, because ex_writes_reg=0.
- Simultaneous flush and hazard: flush wins, no bubble counted.

Optional Feature:
- Macro DECODE_STALL_CNT_EN.
- When defined: adds output stall_count (32 bits).
  - Increments on every cycle in which a hazard bubble is inserted (case 3).
  - Saturates at all-ones; cleared by reset.
- When not defined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset then stream: hold reset 2 cycles, then issue add r3,r1,r2 (R-type) with ex_ready=1 → ex_valid=1 next cycle, ex_writeReg=3, ctrl_readRegA=1 and ctrl_readRegB=2 during the issue cycle.
- jal and I-type select: jal at pc 0x40 → ex_writeReg=15, ex_writes_reg=1; addi r4,r5,7 → ctrl_readRegB=4 (rd), ctrl_readRegA=5.
- Load-use: lw r6 then add r7,r6,r1 back-to-back → id_ready=0 for exactly 1 cycle, one bubble (ex_valid=0), add reaches ID/EX one cycle later; with DECODE_STALL_CNT_EN, stall_count=1.
- No false hazard: lw r0 followed by add r1,r0,r0, and lw r6 followed by j target → no bubble, id_ready stays 1.
- Backpressure: ex_ready=0 for 3 cycles with a valid instruction in ID/EX → ex_* stable and id_ready=0; release → next instruction captured the following cycle.
- Flush: assert flush while a hazard is pending and ex_valid=1 → next cycle ex_valid=0, no bubble counted, the input is not accepted.
